// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction, writeback select
// and a retired-instruction counter.
module mem_wb_stage #(
  parameter int unsigned LINK_OFFSET = 8,
  parameter int unsigned RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                m_valid,
  input  logic [31:0]         m_pc,
  input  logic [31:0]         m_alu_result,
  input  logic [31:0]         m_mem_rdata,
  input  logic [4:0]          m_dest,
  input  logic                m_reg_we,
  input  logic [1:0]          m_wb_sel,
  input  logic [2:0]          m_load_type,
  output logic                w_valid,
  output logic [31:0]         w_pc,
  output logic [4:0]          grf_wa,
  output logic [31:0]         grf_wd,
  output logic                grf_we,
  output logic [RETIRE_W-1:0] retire_count
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  dest;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [2:0]  load_type;
  } mem_wb_t;

  mem_wb_t r;
  logic [RETIRE_W-1:0] cnt;

  // the WB instruction leaves on any non-stalled edge, or when flushed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r   <= '0;
      cnt <= '0;
    end else begin
      if (r.valid && (!stall || flush))
        cnt <= cnt + RETIRE_W'(1);
      if (flush) begin
        r <= '0;
      end else if (!stall) begin
        r.valid     <= m_valid;
        r.pc        <= m_pc;
        r.alu       <= m_alu_result;
        r.rdata     <= m_mem_rdata;
        r.dest      <= m_dest;
        r.reg_we    <= m_reg_we;
        r.wb_sel    <= m_wb_sel;
        r.load_type <= m_load_type;
      end
    end
  end

  logic [1:0]  off;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_data;

  always_comb begin
    off    = r.alu[1:0];
    lane_b = r.rdata[{off, 3'b000} +: 8];
    lane_h = r.rdata[{off[1], 4'b0000} +: 16];
    unique case (r.load_type)
      3'd1:    ld_data = {{24{lane_b[7]}}, lane_b};
      3'd2:    ld_data = {24'h0, lane_b};
      3'd3:    ld_data = {{16{lane_h[15]}}, lane_h};
      3'd4:    ld_data = {16'h0, lane_h};
      default: ld_data = r.rdata;
    endcase
  end

  always_comb begin
    unique case (r.wb_sel)
      2'd0:    grf_wd = r.alu;
      2'd1:    grf_wd = ld_data;
      2'd2:    grf_wd = r.pc + 32'(LINK_OFFSET);
      default: grf_wd = 32'h0;
    endcase
  end

  assign w_valid      = r.valid;
  assign w_pc         = r.pc;
  assign grf_wa       = r.dest;
  assign grf_we       = r.valid & r.reg_we & (r.dest != 5'd0);
  assign retire_count = cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage; small retire counter
// so that wrap-around is reachable.
module tb_mem_wb_stage;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall, flush;
  logic          m_valid, m_reg_we;
  logic [31:0]   m_pc, m_alu_result, m_mem_rdata;
  logic [4:0]    m_dest;
  logic [1:0]    m_wb_sel;
  logic [2:0]    m_load_type;
  logic          w_valid, grf_we;
  logic [31:0]   w_pc, grf_wd;
  logic [4:0]    grf_wa;
  logic [RW-1:0] retire_count;

  mem_wb_stage #(.LINK_OFFSET(8), .RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_pc(m_pc), .m_alu_result(m_alu_result),
    .m_mem_rdata(m_mem_rdata), .m_dest(m_dest), .m_reg_we(m_reg_we),
    .m_wb_sel(m_wb_sel), .m_load_type(m_load_type),
    .w_valid(w_valid), .w_pc(w_pc), .grf_wa(grf_wa), .grf_wd(grf_wd),
    .grf_we(grf_we), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;
  } exp_t;

  exp_t          q[$];
  exp_t          cur;
  logic [RW-1:0] exp_cnt;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_wd(
    input logic [31:0] pc, alu, rd,
    input logic [1:0] sel, input logic [2:0] lt);
    logic [31:0] sb, sh, ld;
    sb = rd >> {alu[1:0], 3'b000};
    sh = rd >> (alu[1] ? 16 : 0);
    case (lt)
      3'd1:    ld = {{24{sb[7]}}, sb[7:0]};
      3'd2:    ld = {24'h0, sb[7:0]};
      3'd3:    ld = {{16{sh[15]}}, sh[15:0]};
      3'd4:    ld = {16'h0, sh[15:0]};
      default: ld = rd;
    endcase
    case (sel)
      2'd0:    return alu;
      2'd1:    return ld;
      2'd2:    return pc + 32'd8;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".valid"}, {31'h0, w_valid}, {31'h0, cur.valid});
    chk({tag, ".pc"}, w_pc, cur.pc);
    chk({tag, ".wa"}, {27'h0, grf_wa}, {27'h0, cur.wa});
    chk({tag, ".wd"}, grf_wd, cur.wd);
    chk({tag, ".we"}, {31'h0, grf_we}, {31'h0, cur.we});
    chk({tag, ".cnt"}, 32'(retire_count), 32'(exp_cnt));
  endtask

  task automatic step(
    input string tag, input logic v, input logic [31:0] pc, alu, rd,
    input logic [4:0] d, input logic we, input logic [1:0] sel,
    input logic [2:0] lt, input logic st, input logic fl);
    exp_t e;
    @(negedge clk);
    m_valid = v; m_pc = pc; m_alu_result = alu; m_mem_rdata = rd;
    m_dest = d; m_reg_we = we; m_wb_sel = sel; m_load_type = lt;
    stall = st; flush = fl;
    if (cur.valid && (!st || fl)) exp_cnt = exp_cnt + 1'b1;
    if (fl) begin
      q.push_back('0);
    end else if (!st) begin
      e.valid = v; e.pc = pc; e.wa = d;
      e.wd = ref_wd(pc, alu, rd, sel, lt);
      e.we = v & we & (d != 5'd0);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (fl || !st) cur = q.pop_front();
    check_outs(tag);
  endtask

  task automatic zero_inputs();
    m_valid = 0; m_pc = 0; m_alu_result = 0; m_mem_rdata = 0;
    m_dest = 0; m_reg_we = 0; m_wb_sel = 0; m_load_type = 0;
    stall = 0; flush = 0;
  endtask

  initial begin
    zero_inputs();
    reset = 1'b1;
    cur = '0;
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("rst");
    @(negedge clk);
    reset = 1'b0;

    // valid LW in flight, then async reset mid-cycle
    step("lw", 1, 32'h100, 32'h40, 32'hCAFEF00D, 5'd5, 1, 2'd1, 3'd0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    cur = '0; exp_cnt = '0; q.delete();
    check_outs("async_rst");
    zero_inputs();
    @(posedge clk);
    #1;
    check_outs("rst_hold");
    @(negedge clk);
    reset = 1'b0;

    // link write
    step("jal", 1, 32'h3000, 32'h0, 32'h0, 5'd31, 1, 2'd2, 3'd0, 0, 0);
    chk("jal_wd", grf_wd, 32'h00003008);
    step("nop", 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 2'd0, 3'd0, 0, 0);
    chk("jal_cnt", 32'(retire_count), 32'd1);

    // load extraction
    step("lb3", 1, 32'h10, 32'h203, 32'h80FF1234, 5'd2, 1, 2'd1, 3'd1, 0, 0);
    chk("lb3_wd", grf_wd, 32'hFFFFFF80);
    step("lbu3", 1, 32'h14, 32'h203, 32'h80FF1234, 5'd2, 1, 2'd1, 3'd2, 0, 0);
    chk("lbu3_wd", grf_wd, 32'h00000080);
    step("lh2", 1, 32'h18, 32'h202, 32'h80FF1234, 5'd3, 1, 2'd1, 3'd3, 0, 0);
    chk("lh2_wd", grf_wd, 32'hFFFF80FF);
    step("lhu2", 1, 32'h1C, 32'h202, 32'h80FF1234, 5'd3, 1, 2'd1, 3'd4, 0, 0);
    chk("lhu2_wd", grf_wd, 32'h000080FF);
    step("lh0", 1, 32'h20, 32'h200, 32'h80FF1234, 5'd4, 1, 2'd1, 3'd3, 0, 0);
    chk("lh0_wd", grf_wd, 32'h00001234);
    step("lt7", 1, 32'h24, 32'h201, 32'h80FF1234, 5'd4, 1, 2'd1, 3'd7, 0, 0);

    // write to r0 suppressed but still retires
    step("r0", 1, 32'h28, 32'h12345678, 32'h0, 5'd0, 1, 2'd0, 3'd0, 0, 0);
    chk("r0_we", {31'h0, grf_we}, 32'h0);

    // valid ADD held through a 3-cycle stall
    step("add", 1, 32'h2C, 32'hAAAA5555, 32'h0, 5'd9, 1, 2'd0, 3'd0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("stall", 1, 32'hDEAD0000 + i, 32'h1, 32'h2, 5'd7, 1, 2'd3,
           3'd1, 1, 0);
    chk("stall_wd", grf_wd, 32'hAAAA5555);
    step("release", 1, 32'h30, 32'h77, 32'h0, 5'd8, 1, 2'd0, 3'd0, 0, 0);

    // flush and stall together
    step("flst", 1, 32'h34, 32'h99, 32'h0, 5'd8, 1, 2'd0, 3'd0, 1, 1);
    chk("flst_we", {31'h0, grf_we}, 32'h0);
    step("flush", 1, 32'h38, 32'h99, 32'h0, 5'd8, 1, 2'd0, 3'd0, 0, 1);

    // mixed traffic
    for (int i = 0; i < 24; i++)
      step("rnd", 1'($urandom), $urandom, $urandom, $urandom,
           5'($urandom), 1'($urandom), 2'($urandom), 3'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));

    // counter wrap
    for (int i = 0; i < 40 && exp_cnt != '1; i++)
      step("fill", 1, 32'h40, 32'h1, 32'h0, 5'd1, 1, 2'd0, 3'd0, 0, 0);
    if (!cur.valid)
      step("fill", 1, 32'h40, 32'h1, 32'h0, 5'd1, 1, 2'd0, 3'd0, 0, 0);
    while (exp_cnt != '1)
      step("fill", 1, 32'h40, 32'h1, 32'h0, 5'd1, 1, 2'd0, 3'd0, 0, 0);
    step("wrap", 1, 32'h44, 32'h2, 32'h0, 5'd1, 1, 2'd0, 3'd0, 0, 0);
    chk("wrap_cnt", 32'(retire_count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
